// File: rtl/regfile_mrw_if.sv
// Register-file access bus: one write port plus NREAD packed read ports.
// The master drives writes and read requests; the slave (the register file)
// returns registered read data.
interface regfile_mrw_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [NREAD-1:0]       rd_en;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input  rd_data);
  modport slave  (input  wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/regfile_mrw.sv
// regfile_mrw: WIDTH x DEPTH register file, one write port, NREAD registered
// read ports, optional hard-wired zero register at DEPTH-1.
// Optional feature macro: REGFILE_MRW_BYPASS_EN -- when defined, a read that
// collides with a same-edge write to the same address returns the new data
// (write-first); otherwise the old storage value is returned (read-first).

// One read port: address lookup plus the output flop.
module regfile_mrw_rdport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic                        en,
  input  logic [AW-1:0]               addr,
  input  logic                        fwd_hit,
  input  logic [WIDTH-1:0]            fwd_data,
  output logic [WIDTH-1:0]            q
);
  logic [WIDTH-1:0] look;
  logic [WIDTH-1:0] nxt;

  // Decode the address; out-of-range and the zero register match nothing and read 0.
  always_comb begin
    look = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == DEPTH-1) && addr == AW'(i)) look = mem[i];
    end
    nxt = fwd_hit ? fwd_data : look;
  end

  // Output register: loads on rd_en, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (en)  q <= nxt;
  end
endmodule

module regfile_mrw #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  regfile_mrw_if.slave   bus
);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ZADDR   = AW'(DEPTH-1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [NREAD-1:0][WIDTH-1:0] rdq;
  logic [NREAD-1:0]            fwd_hit;
  logic                        wr_ok;

  // A write lands only for an in-range, non-zero-register address.
  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W) &&
                 !(ZERO_REG != 0 && bus.wr_addr == ZADDR);

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    // Storage word w: cleared by reset, loaded on a matching accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                               mem[w] <= '0;
      else if (wr_ok && bus.wr_addr == AW'(w))    mem[w] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
`ifdef REGFILE_MRW_BYPASS_EN
    // wr_ok already excludes dropped writes, so they never forward.
    assign fwd_hit[p] = wr_ok && bus.wr_addr == bus.rd_addr[p*AW +: AW];
`else
    assign fwd_hit[p] = 1'b0;
`endif
    regfile_mrw_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk     (clk),
      .reset_n (reset_n),
      .mem     (mem),
      .en      (bus.rd_en[p]),
      .addr    (bus.rd_addr[p*AW +: AW]),
      .fwd_hit (fwd_hit[p]),
      .fwd_data(bus.wr_data),
      .q       (rdq[p])
    );
  end

  assign bus.rd_data = rdq;
endmodule

// File: tb/tb_regfile_mrw.sv
// Self-checking bench for regfile_mrw: three instances (default 64x32x2,
// 64x20x2 for range drops, 32x16x3 for a randomized sweep) against array models.
module tb_regfile_mrw;
`ifdef REGFILE_MRW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_mrw_if #(.WIDTH(64), .AW(5), .NREAD(2)) b0 ();
  regfile_mrw_if #(.WIDTH(64), .AW(5), .NREAD(2)) b1 ();
  regfile_mrw_if #(.WIDTH(32), .AW(4), .NREAD(3)) b2 ();

  regfile_mrw #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  regfile_mrw #(.WIDTH(64), .DEPTH(20), .NREAD(2), .ZERO_REG(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  regfile_mrw #(.WIDTH(32), .DEPTH(16), .NREAD(3), .ZERO_REG(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));

  // Reference state for u0 and u2: register contents and expected port values.
  logic [63:0] m0 [32];
  logic [63:0] e0 [2];
  logic [31:0] m2 [16];
  logic [31:0] e2 [3];

  task automatic clear_models();
    for (int i = 0; i < 32; i++) m0[i] = '0;
    for (int i = 0; i < 16; i++) m2[i] = '0;
    for (int p = 0; p < 2; p++) e0[p] = '0;
    for (int p = 0; p < 3; p++) e2[p] = '0;
  endtask

  // One u0 cycle: drive, predict from the register-file rules, clock, settle.
  task automatic cyc0(input bit we, input int wa, input logic [63:0] wd,
                      input logic [1:0] re, input int ra0, input int ra1);
    int ra [2];
    ra[0] = ra0; ra[1] = ra1;
    b0.wr_en = we; b0.wr_addr = 5'(wa); b0.wr_data = wd;
    b0.rd_en = re; b0.rd_addr = {5'(ra1), 5'(ra0)};
    for (int p = 0; p < 2; p++) begin
      if (re[p]) begin
        if (ra[p] >= 31)                     e0[p] = '0;
        else if (BYP && we && wa == ra[p])   e0[p] = wd;
        else                                 e0[p] = m0[ra[p]];
      end
    end
    if (we && wa < 31) m0[wa] = wd;
    @(posedge clk); #1;
    b0.wr_en = 1'b0; b0.rd_en = '0;
  endtask

  task automatic test_reset();
    #2;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (b0.rd_data[p*64 +: 64] !== 64'h0) begin
        errs++; $display("FAIL reset_init port%0d got %h exp 0", p, b0.rd_data[p*64 +: 64]);
      end
    end
    checks++;
    if (b2.rd_data !== 96'h0) begin
      errs++; $display("FAIL reset_init_u2 got %h exp 0", b2.rd_data);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    cyc0(1, 5, 64'hDEAD_BEEF, 2'b00, 0, 0);
    cyc0(0, 0, 0, 2'b11, 5, 5);
    checks++;
    if (b0.rd_data[63:0] !== 64'hDEAD_BEEF) begin
      errs++; $display("FAIL reset_prewrite got %h exp %h", b0.rd_data[63:0], 64'hDEAD_BEEF);
    end
    // Asynchronous assertion away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (b0.rd_data !== 128'h0) begin
      errs++; $display("FAIL reset_async got %h exp 0", b0.rd_data);
    end
    clear_models();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    cyc0(0, 0, 0, 2'b01, 5, 0);
    checks++;
    if (b0.rd_data[63:0] !== 64'h0) begin
      errs++; $display("FAIL reset_cleared got %h exp 0", b0.rd_data[63:0]);
    end
  endtask

  task automatic test_latency();
    cyc0(1, 3, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0);
    checks++;
    if (b0.rd_data[63:0] !== 64'h0) begin
      errs++; $display("FAIL lat_no_read got %h exp 0", b0.rd_data[63:0]);
    end
    cyc0(0, 0, 0, 2'b01, 3, 0);
    checks++;
    if (b0.rd_data[63:0] !== 64'h0123_4567_89AB_CDEF) begin
      errs++; $display("FAIL lat_read got %h exp %h", b0.rd_data[63:0], 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_zero_range();
    cyc0(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0);
    cyc0(0, 0, 0, 2'b11, 31, 31);
    checks++;
    if (b0.rd_data !== 128'h0) begin
      errs++; $display("FAIL zero_reg31 got %h exp 0", b0.rd_data);
    end
    // u1: DEPTH=20, address 25 out of range, 19 is the zero register.
    b1.wr_en = 1'b1; b1.wr_addr = 5'd25; b1.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    b1.wr_addr = 5'd19;
    @(posedge clk); #1;
    b1.wr_addr = 5'd10; b1.wr_data = 64'h1234;
    @(posedge clk); #1;
    b1.wr_en = 1'b0; b1.rd_en = 2'b11; b1.rd_addr = {5'd19, 5'd25};
    @(posedge clk); #1;
    checks++;
    if (b1.rd_data !== 128'h0) begin
      errs++; $display("FAIL range_drop got %h exp 0", b1.rd_data);
    end
    b1.rd_addr = {5'd10, 5'd10};
    @(posedge clk); #1;
    checks++;
    if (b1.rd_data !== {64'h1234, 64'h1234}) begin
      errs++; $display("FAIL range_valid got %h exp both 1234", b1.rd_data);
    end
    b1.rd_en = '0;
  endtask

  task automatic test_collision();
    logic [63:0] want;
    cyc0(1, 7, 64'h1, 2'b00, 0, 0);
    cyc0(1, 7, 64'hA5A5, 2'b11, 7, 7);
    want = BYP ? 64'hA5A5 : 64'h1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (b0.rd_data[p*64 +: 64] !== want) begin
        errs++; $display("FAIL collide port%0d got %h exp %h", p, b0.rd_data[p*64 +: 64], want);
      end
    end
    cyc0(0, 0, 0, 2'b01, 7, 0);
    checks++;
    if (b0.rd_data[63:0] !== 64'hA5A5) begin
      errs++; $display("FAIL collide_after got %h exp a5a5", b0.rd_data[63:0]);
    end
    // Collision on the zero register must never forward.
    cyc0(1, 31, 64'h77, 2'b11, 31, 31);
    checks++;
    if (b0.rd_data !== 128'h0) begin
      errs++; $display("FAIL collide_zero got %h exp 0", b0.rd_data);
    end
  endtask

  task automatic test_multiport_hold();
    logic [63:0] h0, h1;
    for (int i = 0; i < 32; i++) cyc0(1, i, 64'(i) * 64'h0000010204080001, 2'b00, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc0(0, 0, 0, 2'b11, i, 31 - i);
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (b0.rd_data[p*64 +: 64] !== e0[p]) begin
          errs++; $display("FAIL sweep i=%0d port%0d got %h exp %h", i, p, b0.rd_data[p*64 +: 64], e0[p]);
        end
      end
    end
    h0 = e0[0]; h1 = e0[1];
    for (int k = 0; k < 3; k++) begin
      cyc0(1, 4 + k, 64'hBAD0 + 64'(k), 2'b00, k + 9, 20 - k);
      checks++;
      if (b0.rd_data !== {h1, h0}) begin
        errs++; $display("FAIL hold k=%0d got %h exp %h", k, b0.rd_data, {h1, h0});
      end
    end
  endtask

  task automatic test_random_sweep();
    bit we;
    int wa;
    int ra [3];
    logic [31:0] wd;
    logic [2:0] re;
    for (int c = 0; c < 1000; c++) begin
      we = 1'($urandom);
      wa = int'($urandom_range(0, 15));
      wd = $urandom;
      re = 3'($urandom);
      for (int p = 0; p < 3; p++) ra[p] = (c % 4 == 0) ? wa : int'($urandom_range(0, 15));
      b2.wr_en = we; b2.wr_addr = 4'(wa); b2.wr_data = wd; b2.rd_en = re;
      b2.rd_addr = {4'(ra[2]), 4'(ra[1]), 4'(ra[0])};
      for (int p = 0; p < 3; p++) begin
        if (re[p]) begin
          if (ra[p] == 15)                     e2[p] = '0;
          else if (BYP && we && wa == ra[p])   e2[p] = wd;
          else                                 e2[p] = m2[ra[p]];
        end
      end
      if (we && wa != 15) m2[wa] = wd;
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (b2.rd_data[p*32 +: 32] !== e2[p]) begin
          errs++; $display("FAIL rand c=%0d port%0d got %h exp %h", c, p, b2.rd_data[p*32 +: 32], e2[p]);
        end
      end
    end
    b2.wr_en = 1'b0; b2.rd_en = '0;
  endtask

  initial begin
    b0.wr_en = 0; b0.wr_addr = '0; b0.wr_data = '0; b0.rd_en = '0; b0.rd_addr = '0;
    b1.wr_en = 0; b1.wr_addr = '0; b1.wr_data = '0; b1.rd_en = '0; b1.rd_addr = '0;
    b2.wr_en = 0; b2.wr_addr = '0; b2.wr_data = '0; b2.rd_en = '0; b2.rd_addr = '0;
    clear_models();
    test_reset();
    test_latency();
    test_zero_range();
    test_collision();
    test_multiport_hold();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mrw.md
# regfile_mrw

Parametrised multi-port register file for the datapath's decode stage, generalising the fixed 32-entry, 64-bit read-select path into a clocked storage array. Provides one synchronous write port and NREAD registered read ports with configurable width, depth and an optional hard-wired zero register (ARM XZR convention). An optional write-to-read bypass, selected by a macro, gives same-cycle write-first forwarding for the pipeline.

## Interface
- WIDTH, 64, bits per register
- DEPTH, 32, number of registers (2..256; need not be a power of two)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register DEPTH-1 always reads 0 and ignores writes
- Derived: AW = $clog2(DEPTH)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write strobe
- wr_addr  input  AW  write register index
- wr_data  input  WIDTH  write value
- rd_en  input  NREAD  per-port read strobe
- rd_addr  input  NREAD*AW  packed read indices; port p at [p*AW +: AW]
- rd_data  output  NREAD*WIDTH  packed registered read data; port p at [p*WIDTH +: WIDTH]

## Operation
- Reset (reset_n low, any time, including mid-operation): every storage word and every rd_data port clears to 0 immediately; wr_en and rd_en are ignored while reset_n is low.
- Write: on a rising edge with wr_en=1, storage[wr_addr] <= wr_data.
- Writes are dropped when wr_addr >= DEPTH, or when ZERO_REG=1 and wr_addr == DEPTH-1.
- Read: on a rising edge with rd_en[p]=1, rd_data[p] loads the value of storage[rd_addr[p]].
- With rd_en[p]=0, rd_data[p] holds its previous value.
- A read loads 0 when rd_addr[p] >= DEPTH, or when ZERO_REG=1 and rd_addr[p] == DEPTH-1.
- All NREAD ports operate independently. Any number of ports may read the same address in the same cycle and each gets the same value.
- Same-cycle write and read to the same valid, non-zero address: behaviour depends on the macro (see Configuration).
- No state machine. The storage array is the only state besides the rd_data registers.

## Timing
- Write latency: one edge. Data written at edge N is visible to a read sampled at edge N+1, appearing on rd_data after edge N+1.
- Read latency: one cycle. rd_data[p] is valid after the edge at which rd_en[p] was sampled high.
- Reset is asynchronous on assertion. The first rising edge with reset_n high performs normal writes and reads.
- rd_data is driven only from flops; there is no combinational path from inputs to outputs.

## Configuration
- Macro: REGFILE_MRW_BYPASS_EN.
- Defined: when wr_en=1 and rd_en[p]=1 with wr_addr == rd_addr[p] at the same edge, rd_data[p] loads wr_data (write-first).
  - Bypass does not apply to dropped writes (zero register, out-of-range address); those reads still return 0.
- Undefined: the same collision makes rd_data[p] load the old storage value (read-first). The new value is visible from the next read.

## Test plan
- Reset check: drive reset_n low mid-run after writing 64'hDEAD_BEEF to reg 5. Required: rd_data is 0 immediately (asynchronous clear), and a read of reg 5 after release returns 0.
- Write/read latency: write 64'h0123_4567_89AB_CDEF to reg 3, then read port 0 of reg 3 on the next edge. Required: rd_data[0] equals the value one cycle after the read edge.
- Zero register and range (DEPTH=32, ZERO_REG=1): write 64'hFFFF_FFFF_FFFF_FFFF to reg 31, then read it. Required: 0. Repeat with DEPTH=20 and address 25. Required: write dropped, read returns 0.
- Collision: in the same cycle, write 64'hA5A5 to reg 7 and read reg 7 on both ports (prior value 64'h1). Required: both ports show 64'hA5A5 with the macro defined and 64'h1 without it.
- Multi-port and hold: fill regs 0..31 with i*64'h0000010204080001. Sweep port 0 ascending and port 1 descending and check every value. Then drop rd_en for 3 cycles while changing rd_addr. Required: rd_data holds the last values.
- Parameter sweep: WIDTH=32, DEPTH=16, NREAD=3 with random writes and reads against a reference model for 1000 cycles. Required: no mismatches.
